// File: rtl/key_debounce_array.sv
// -----------------------------------------------------------------------------
// key_debounce_array
//
// Multi-channel key debouncer. Every channel synchronises its raw pin with a
// two-flop synchroniser and runs its own four-state debounce machine. A level
// change is accepted only after the pin has been stable for DB_CYCLES clocks.
// Each channel outputs a debounced level and one-cycle press, release and
// long-press strobes.
//
// Parameters
//   KEY_NUM      number of independent channels (>= 1)
//   DB_CYCLES    stable clocks required to accept a level change (>= 1)
//   LONG_CYCLES  held clocks after press acceptance before Long_Pulse
//                (0 disables long-press detection)
//   IDLE_LEVEL   pin level of a released key (1 = active-low keys)
//
// Ports
//   CLK            in   system clock, rising edge
//   RST_n          in   asynchronous active-low reset
//   Pin_In         in   raw key pins, asynchronous to CLK
//   Key_State      out  debounced level per channel, 1 = pressed
//   Press_Pulse    out  one-cycle strobe on accepted press
//   Release_Pulse  out  one-cycle strobe on accepted release
//   Long_Pulse     out  one-cycle strobe, at most once per accepted press
//
// All outputs are registered and reset to 0.
// -----------------------------------------------------------------------------
module key_debounce_array #(
  parameter int   KEY_NUM     = 4,
  parameter int   DB_CYCLES   = 1_000_000,
  parameter int   LONG_CYCLES = 50_000_000,
  parameter logic IDLE_LEVEL  = 1'b1
) (
  input  logic               CLK,
  input  logic               RST_n,
  input  logic [KEY_NUM-1:0] Pin_In,
  output logic [KEY_NUM-1:0] Key_State,
  output logic [KEY_NUM-1:0] Press_Pulse,
  output logic [KEY_NUM-1:0] Release_Pulse,
  output logic [KEY_NUM-1:0] Long_Pulse
);

  // Counter widths. With long-press disabled the long counter is kept one bit
  // wide so that no zero-width vector is ever declared.
  localparam int DW = $clog2(DB_CYCLES + 1);
  localparam int LW = (LONG_CYCLES > 0) ? $clog2(LONG_CYCLES + 1) : 1;

  localparam bit            LONG_EN   = (LONG_CYCLES != 0);
  localparam logic [DW-1:0] DB_LAST   = DW'(DB_CYCLES - 1);
  localparam logic [LW-1:0] LONG_MAX  = LW'(LONG_CYCLES);
  localparam logic [LW-1:0] LONG_LAST = LW'((LONG_CYCLES > 0) ? LONG_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    RELEASED     = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } key_fsm_e;

  // ---------------------------------------------------------------------------
  // Two-flop synchroniser, reset to the released level so that a key held
  // through reset must requalify through PRESS_WAIT.
  // ---------------------------------------------------------------------------
  logic [KEY_NUM-1:0] sync1_q;
  logic [KEY_NUM-1:0] sync2_q;
  logic [KEY_NUM-1:0] act;

  // NOTE: sequential state uses non-blocking assignments so that every flop
  // samples the pre-edge value of its inputs, whatever the block ordering.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1_q <= {KEY_NUM{IDLE_LEVEL}};
      sync2_q <= {KEY_NUM{IDLE_LEVEL}};
    end else begin
      sync1_q <= Pin_In;
      sync2_q <= sync1_q;
    end
  end

  // A channel is active when its synchronised pin differs from the idle level.
  assign act = sync2_q ^ {KEY_NUM{IDLE_LEVEL}};

  // ---------------------------------------------------------------------------
  // Per-channel debounce machine
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < KEY_NUM; g++) begin : g_ch
    key_fsm_e      state_q, state_d;
    logic [DW-1:0] db_q, db_d;
    logic [LW-1:0] long_q, long_d;
    logic          done_q, done_d;
    logic          key_q, key_d;
    logic          press_q, press_d;
    logic          rel_q, rel_d;
    logic          lpulse_q, lpulse_d;

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
      state_d  = state_q;
      db_d     = db_q;
      long_d   = long_q;
      done_d   = done_q;
      press_d  = 1'b0;
      rel_d    = 1'b0;
      lpulse_d = 1'b0;

      // Long timing runs for as long as the key is accepted as held,
      // including release bounces, and saturates at its terminal value.
      if ((state_q == PRESSED || state_q == RELEASE_WAIT) && long_q != LONG_MAX) begin
        long_d = long_q + LW'(1);
      end

      case (state_q)
        RELEASED: begin
          if (act[g]) begin
            state_d = PRESS_WAIT;
            db_d    = '0;
          end
        end
        PRESS_WAIT: begin
          if (!act[g]) begin
            state_d = RELEASED;            // glitch rejected, no pulse
          end else if (db_q == DB_LAST) begin
            state_d = PRESSED;
            press_d = 1'b1;
            long_d  = '0;
            done_d  = 1'b0;
          end else begin
            db_d = db_q + DW'(1);
          end
        end
        PRESSED: begin
          if (!act[g]) begin
            state_d = RELEASE_WAIT;
            db_d    = '0;
          end
        end
        RELEASE_WAIT: begin
          // Returning to PRESSED keeps the long counter, so a release bounce
          // does not restart long-press timing.
          if (act[g]) begin
            state_d = PRESSED;
          end else if (db_q == DB_LAST) begin
            state_d = RELEASED;
            rel_d   = 1'b1;
          end else begin
            db_d = db_q + DW'(1);
          end
        end
        default: begin
          state_d = RELEASED;
        end
      endcase

      // done_q limits the long-press strobe to once per accepted press.
      if (LONG_EN && state_q == PRESSED && long_q == LONG_LAST && !done_q) begin
        lpulse_d = 1'b1;
        done_d   = 1'b1;
      end

      key_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end

    // NOTE: counters and flags are reset along with the state so that a reset
    // mid-press leaves no stale timing behind; there are no memories here.
    always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
        state_q  <= RELEASED;
        db_q     <= '0;
        long_q   <= '0;
        done_q   <= 1'b0;
        key_q    <= 1'b0;
        press_q  <= 1'b0;
        rel_q    <= 1'b0;
        lpulse_q <= 1'b0;
      end else begin
        state_q  <= state_d;
        db_q     <= db_d;
        long_q   <= long_d;
        done_q   <= done_d;
        key_q    <= key_d;
        press_q  <= press_d;
        rel_q    <= rel_d;
        lpulse_q <= lpulse_d;
      end
    end

    assign Key_State[g]     = key_q;
    assign Press_Pulse[g]   = press_q;
    assign Release_Pulse[g] = rel_q;
    assign Long_Pulse[g]    = lpulse_q;
  end

endmodule
